// File: rtl/alarm_pkg.sv
// Shared constants for the anti-theft alarm controller: state codes,
// default countdown intervals and handshake guard length.
package alarm_pkg;

  localparam int STATE_W = 3;
  localparam int VALUE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUND      = 3'd2,
    HOLD       = 3'd3,
    DISARMED   = 3'd4,
    WAIT_OPEN  = 3'd5,
    WAIT_CLOSE = 3'd6,
    ARM_DELAY  = 3'd7
  } state_t;

  localparam logic [VALUE_W-1:0] T_ARM       = 4'd6;
  localparam logic [VALUE_W-1:0] T_DRIVER    = 4'd8;
  localparam logic [VALUE_W-1:0] T_PASSENGER = 4'd15;
  localparam logic [VALUE_W-1:0] T_ALARM     = 4'd10;

  // expired is ignored in the start cycle and the two cycles after it
  localparam logic [1:0] GUARD_LOAD = 2'd3;

endpackage

// File: rtl/timer_handshake.sv
// Start-pulse generator toward the countdown timer: registers the interval,
// retries a start the timer dropped, and masks expiries during the guard window.
module timer_handshake
  import alarm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               request,
  input  logic [VALUE_W-1:0] request_value,
  input  logic               expired,
  output logic               start_timer,
  output logic [VALUE_W-1:0] value,
  output logic               expired_ok
);

  logic [1:0] guard_q;
  logic       retry;

  // expired during a start cycle means the timer was in DONE and dropped it
  assign retry      = start_timer & expired;
  assign expired_ok = expired & ~start_timer & (guard_q == 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_timer <= 1'b0;
      value       <= '0;
      guard_q     <= 2'd0;
    end else begin
      start_timer <= request | retry;
      if (request) begin
        value <= request_value;
      end
      if (request || retry) begin
        guard_q <= GUARD_LOAD;
      end else if (guard_q != 2'd0) begin
        guard_q <= guard_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Main alarm state machine: watches ignition and doors, sequences the
// countdown timer and drives siren, status LED and the debug state code.
//
// state      | meaning
// ARMED      | waiting for a door to open
// TRIGGERED  | entry countdown running
// SOUND      | siren on, waiting for doors to close
// HOLD       | siren on, post-close countdown running
// DISARMED   | ignition on
// WAIT_OPEN  | ignition off, waiting for driver to leave
// WAIT_CLOSE | waiting for all doors closed
// ARM_DELAY  | arming countdown running
module alarm_controller
  import alarm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic               door_driver,
  input  logic               door_pass,
  input  logic               reprogram,
  input  logic               expired,
  input  logic               one_hz_enable,
  output logic               start_timer,
  output logic [VALUE_W-1:0] value,
  output logic               siren,
  output logic               status_led,
  output logic [STATE_W-1:0] state_display
);

  state_t             state_q;
  state_t             state_d;
  logic               req;
  logic [VALUE_W-1:0] req_value;
  logic               expired_ok;
  logic               any_door;

  assign any_door      = door_driver | door_pass;
  assign state_display = state_q;

  timer_handshake u_handshake (
    .clock         (clock),
    .reset         (reset),
    .request       (req),
    .request_value (req_value),
    .expired       (expired),
    .start_timer   (start_timer),
    .value         (value),
    .expired_ok    (expired_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    req_value = '0;
    if (reprogram) begin
      state_d = ARMED;
    end else if (ignition && state_q != ARMED && state_q != DISARMED) begin
      state_d = DISARMED;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (any_door) begin
            state_d   = TRIGGERED;
            req       = 1'b1;
            req_value = door_driver ? T_DRIVER : T_PASSENGER;
          end
        end
        TRIGGERED: begin
          if (expired_ok) state_d = SOUND;
        end
        SOUND: begin
          if (!any_door) begin
            state_d   = HOLD;
            req       = 1'b1;
            req_value = T_ALARM;
          end
        end
        HOLD: begin
          // a reopened door wins over a coincident expiry
          if (any_door)        state_d = SOUND;
          else if (expired_ok) state_d = ARMED;
        end
        DISARMED: begin
          if (!ignition) state_d = WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (door_driver) state_d = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (!any_door) begin
            state_d   = ARM_DELAY;
            req       = 1'b1;
            req_value = T_ARM;
          end
        end
        ARM_DELAY: begin
          if (any_door)        state_d = WAIT_CLOSE;
          else if (expired_ok) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      siren      <= 1'b0;
      status_led <= 1'b0;
    end else begin
      siren <= (state_d == SOUND) || (state_d == HOLD);
      unique case (state_d)
        ARMED:                 status_led <= one_hz_enable;
        TRIGGERED, SOUND, HOLD: status_led <= 1'b1;
        default:               status_led <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: stimulus queues expected events,
// a negedge monitor pops and compares on every state change or start pulse.
module tb_alarm_controller;

  logic       clock;
  logic       reset;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic       expired;
  logic       one_hz_enable;
  logic       start_timer;
  logic [3:0] value;
  logic       siren;
  logic       status_led;
  logic [2:0] state_display;

  localparam logic [2:0] S_ARMED = 3'd0, S_TRIG = 3'd1, S_SOUND = 3'd2, S_HOLD = 3'd3,
                         S_DIS = 3'd4, S_WOPEN = 3'd5, S_WCLOSE = 3'd6, S_ADELAY = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       start;
    logic [3:0] val;
    logic       sir;
    logic       led;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] prev_st = 3'd0;

  alarm_controller dut (
    .clock         (clock),
    .reset         (reset),
    .ignition      (ignition),
    .door_driver   (door_driver),
    .door_pass     (door_pass),
    .reprogram     (reprogram),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .start_timer   (start_timer),
    .value         (value),
    .siren         (siren),
    .status_led    (status_led),
    .state_display (state_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (state_display != prev_st || start_timer) begin
      ev_t act;
      act = '{st: state_display, start: start_timer, val: value, sir: siren, led: status_led};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got st=%0d start=%0b value=%0d siren=%0b led=%0b, expected no event",
                 act.st, act.start, act.val, act.sir, act.led);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL event: got st=%0d start=%0b value=%0d siren=%0b led=%0b, expected st=%0d start=%0b value=%0d siren=%0b led=%0b",
                   act.st, act.start, act.val, act.sir, act.led, e.st, e.start, e.val, e.sir, e.led);
        end
      end
    end
    prev_st = state_display;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input logic start, input logic [3:0] val,
                      input logic sir, input logic led);
    exp_q.push_back('{st: st, start: start, val: val, sir: sir, led: led});
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic go_arm_delay();
    door_driver = 1'b1;
    push(S_TRIG, 1'b1, 4'd8, 1'b0, 1'b1);
    tick();
    ignition = 1'b1;
    door_driver = 1'b0;
    push(S_DIS, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    ignition = 1'b0;
    push(S_WOPEN, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    door_driver = 1'b1;
    push(S_WCLOSE, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    door_driver = 1'b0;
    push(S_ADELAY, 1'b1, 4'd6, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    ignition = 1'b0;
    door_driver = 1'b0;
    door_pass = 1'b0;
    reprogram = 1'b0;
    expired = 1'b0;
    one_hz_enable = 1'b1;
    #12;
    check("reset_state", state_display, 0);
    check("reset_start", start_timer, 0);
    check("reset_value", value, 0);
    check("reset_siren", siren, 0);
    check("reset_led", status_led, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("led_after_reset", status_led, 1);

    // ignition alone does nothing in ARMED
    ignition = 1'b1;
    tick();
    tick();
    check("ignition_ignored_armed", state_display, S_ARMED);
    ignition = 1'b0;

    // 1: passenger door triggers, expiry sounds
    door_pass = 1'b1;
    push(S_TRIG, 1'b1, 4'd15, 1'b0, 1'b1);
    tick();
    repeat (20) tick();
    expired = 1'b1;
    push(S_SOUND, 1'b0, 4'd15, 1'b1, 1'b1);
    tick();
    expired = 1'b0;

    // 2: hold, reopen, stale expiry, close, expire
    door_pass = 1'b0;
    push(S_HOLD, 1'b1, 4'd10, 1'b1, 1'b1);
    tick();
    repeat (4) tick();
    door_driver = 1'b1;
    push(S_SOUND, 1'b0, 4'd10, 1'b1, 1'b1);
    tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
    check("stale_expired_sound", state_display, S_SOUND);
    door_driver = 1'b0;
    push(S_HOLD, 1'b1, 4'd10, 1'b1, 1'b1);
    tick();
    repeat (5) tick();
    expired = 1'b1;
    push(S_ARMED, 1'b0, 4'd10, 1'b0, 1'b1);
    tick();
    expired = 1'b0;

    // 3: both doors (driver wins), disarm and re-arm sequence
    door_driver = 1'b1;
    door_pass = 1'b1;
    push(S_TRIG, 1'b1, 4'd8, 1'b0, 1'b1);
    tick();
    door_pass = 1'b0;
    repeat (3) tick();
    ignition = 1'b1;
    push(S_DIS, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    door_driver = 1'b0;
    tick();
    check("disarmed_hold", state_display, S_DIS);
    ignition = 1'b0;
    push(S_WOPEN, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    tick();
    door_driver = 1'b1;
    push(S_WCLOSE, 1'b0, 4'd8, 1'b0, 1'b0);
    tick();
    door_driver = 1'b0;
    push(S_ADELAY, 1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    repeat (5) tick();
    expired = 1'b1;
    push(S_ARMED, 1'b0, 4'd6, 1'b0, 1'b1);
    tick();
    expired = 1'b0;

    // 4: door reopened in ARM_DELAY wins over a coincident expiry
    go_arm_delay();
    repeat (4) tick();
    door_pass = 1'b1;
    expired = 1'b1;
    push(S_WCLOSE, 1'b0, 4'd6, 1'b0, 1'b0);
    tick();
    expired = 1'b0;
    door_pass = 1'b0;
    push(S_ADELAY, 1'b1, 4'd6, 1'b0, 1'b0);
    tick();

    // 5: retry on expiry during start, then guard window
    expired = 1'b1;
    push(S_ADELAY, 1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    expired = 1'b0;
    tick();
    expired = 1'b1;
    tick();
    check("guard_1_after", state_display, S_ADELAY);
    tick();
    check("guard_2_after", state_display, S_ADELAY);
    push(S_ARMED, 1'b0, 4'd6, 1'b0, 1'b1);
    tick();
    expired = 1'b0;
    check("honoured_3_after", state_display, S_ARMED);

    // 6: async reset in HOLD, then reprogram in TRIGGERED
    door_pass = 1'b1;
    push(S_TRIG, 1'b1, 4'd15, 1'b0, 1'b1);
    tick();
    repeat (5) tick();
    expired = 1'b1;
    push(S_SOUND, 1'b0, 4'd15, 1'b1, 1'b1);
    tick();
    expired = 1'b0;
    door_pass = 1'b0;
    push(S_HOLD, 1'b1, 4'd10, 1'b1, 1'b1);
    tick();
    tick();
    #1;
    push(S_ARMED, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("async_reset_state", state_display, 0);
    check("async_reset_siren", siren, 0);
    check("async_reset_led", status_led, 0);
    check("async_reset_value", value, 0);
    tick();
    tick();
    @(negedge clock);
    reset = 1'b0;
    repeat (4) tick();
    check("no_start_after_reset", start_timer, 0);
    door_pass = 1'b1;
    push(S_TRIG, 1'b1, 4'd15, 1'b0, 1'b1);
    tick();
    tick();
    reprogram = 1'b1;
    door_pass = 1'b0;
    push(S_ARMED, 1'b0, 4'd15, 1'b0, 1'b1);
    tick();
    reprogram = 1'b0;
    repeat (3) tick();

    // LED follows one_hz_enable while armed
    one_hz_enable = 1'b0;
    tick();
    check("led_follow_low", status_led, 0);
    one_hz_enable = 1'b1;
    tick();
    check("led_follow_high", status_led, 1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
